// File: rtl/int_to_fp_converter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_to_fp_converter_pkg
//  Brief    : Shared constants, packed-format layout, FSM state type and a
//             result packing helper for the integer-to-float converter.
//  Revision : 1.0 - initial release
// ============================================================================
package int_to_fp_converter_pkg;

  // Datapath widths
  localparam int SIZE_INT             = 32;
  localparam int SIZE_MANTISSA        = 24;  // 1.M, 23 stored fraction bits
  localparam int SIZE_EXPONENT        = 8;
  localparam int SIZE_EXCEPTION_FIELD = 2;
  localparam int SIZE                 = SIZE_MANTISSA + SIZE_EXPONENT + SIZE_EXCEPTION_FIELD;
  localparam int BIAS                 = 127;
  localparam int COARSE_STEP          = 4;

  // Bit offsets of the packed format {exception, sign, exponent, fraction}
  localparam int FRACTION_LSB  = 0;
  localparam int EXPONENT_LSB  = SIZE_MANTISSA - 1;
  localparam int SIGN_BIT      = EXPONENT_LSB + SIZE_EXPONENT;
  localparam int EXCEPTION_LSB = SIGN_BIT + 1;

  // Exception codes
  localparam logic [SIZE_EXCEPTION_FIELD-1:0] EXC_ZERO          = 2'b00;
  localparam logic [SIZE_EXCEPTION_FIELD-1:0] EXC_NORMAL_NUMBER = 2'b01;
  localparam logic [SIZE_EXCEPTION_FIELD-1:0] EXC_INFINITY      = 2'b10;
  localparam logic [SIZE_EXCEPTION_FIELD-1:0] EXC_NAN           = 2'b11;

  // Conversion selector shared with the adder/multiplier datapaths
  localparam logic [1:0] SEL_FP_OPERATION  = 2'b00;
  localparam logic [1:0] SEL_FP_TO_INT     = 2'b01;
  localparam logic [1:0] SEL_INT_OPERATION = 2'b10;

  // Converter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Assemble a packed result word from its fields
  function automatic logic [SIZE-1:0] pack_result(
    input logic [SIZE_EXCEPTION_FIELD-1:0] exc,
    input logic                            sign,
    input logic [SIZE_EXPONENT-1:0]        exponent,
    input logic [SIZE_MANTISSA-2:0]        fraction
  );
    return {exc, sign, exponent, fraction};
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_to_fp_converter_rne_rounder.sv
`default_nettype none
// ============================================================================
//  Module   : rne_rounder
//  Brief    : Combinational round-to-nearest-even of a normalised 32-bit
//             magnitude down to a 24-bit 1.M mantissa, with exponent bump on
//             mantissa carry-out.
//  Revision : 1.0 - initial release
// ============================================================================
module rne_rounder
  import int_to_fp_converter_pkg::*;
(
  input  logic [SIZE_INT-1:0]      mag_i,
  input  logic [SIZE_EXPONENT:0]   exp_i,
  output logic [SIZE_MANTISSA-1:0] mantissa_o,
  output logic [SIZE_EXPONENT:0]   exp_o
);

  // Bits below the kept mantissa: guard is the top one, sticky ORs the rest
  localparam int DROP = SIZE_INT - SIZE_MANTISSA;

  logic [SIZE_MANTISSA-1:0] w_kept;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_round_up;
  logic [SIZE_MANTISSA:0]   w_sum;

  // Round half to even; a carry out means the mantissa wrapped to 10.000..0
  always_comb begin
    w_kept     = mag_i[SIZE_INT-1 -: SIZE_MANTISSA];
    w_guard    = mag_i[DROP-1];
    w_sticky   = |mag_i[DROP-2:0];
    w_round_up = w_guard & (w_sticky | w_kept[0]);
    w_sum      = {1'b0, w_kept} + {{SIZE_MANTISSA{1'b0}}, w_round_up};
    if (w_sum[SIZE_MANTISSA]) begin
      mantissa_o = {1'b1, {(SIZE_MANTISSA-1){1'b0}}};
      exp_o      = exp_i + {{SIZE_EXPONENT{1'b0}}, 1'b1};
    end else begin
      mantissa_o = w_sum[SIZE_MANTISSA-1:0];
      exp_o      = exp_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_to_fp_converter.sv
`default_nettype none
// ============================================================================
//  Module   : int_to_fp_converter
//  Brief    : Sequential 32-bit signed/unsigned integer to packed internal
//             float converter. Iterative coarse (4-bit) / fine (1-bit)
//             normalisation, round-to-nearest-even, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module int_to_fp_converter
  import int_to_fp_converter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_signed,
  input  logic [SIZE_INT-1:0] int_number_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     resulted_number_o
);

  // Exponent of an integer whose MSB sits at bit SIZE_INT-1
  localparam logic [SIZE_EXPONENT:0] EXP_START = (SIZE_EXPONENT+1)'(BIAS + SIZE_INT - 1);
  localparam logic [SIZE_EXPONENT:0] EXP_COARSE = (SIZE_EXPONENT+1)'(COARSE_STEP);
  localparam logic [SIZE_EXPONENT:0] EXP_FINE   = (SIZE_EXPONENT+1)'(1);

  state_e                   state_q, state_d;
  logic [SIZE_INT-1:0]      mag_q, mag_d;
  logic [SIZE_EXPONENT:0]   exp_q, exp_d;
  logic                     sign_q, sign_d;
  logic [SIZE-1:0]          result_q, result_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic                     w_in_sign;
  logic [SIZE_INT-1:0]      w_in_mag;
  logic [SIZE_MANTISSA-1:0] w_rnd_mantissa;
  logic [SIZE_EXPONENT:0]   w_rnd_exp;

  // The hidden bit and the exponent's headroom bit are never part of the word
  logic                     unused_rnd_bits;
  assign unused_rnd_bits = w_rnd_mantissa[SIZE_MANTISSA-1] ^ w_rnd_exp[SIZE_EXPONENT];

  // Operand sign and magnitude; -2^31 negates to itself, which is the correct unsigned magnitude
  always_comb begin
    w_in_sign = is_signed & int_number_i[SIZE_INT-1];
    w_in_mag  = w_in_sign ? -int_number_i : int_number_i;
  end

  rne_rounder u_rne_rounder (
    .mag_i      (mag_q),
    .exp_i      (exp_q),
    .mantissa_o (w_rnd_mantissa),
    .exp_o      (w_rnd_exp)
  );

  // Next-state logic: accept, normalise, round, then hold until consumed
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d     = w_in_sign;
          mag_d      = w_in_mag;
          exp_d      = EXP_START;
          in_ready_d = 1'b0;
          if (w_in_mag == '0) begin
            // Zero skips normalisation entirely and uses the all-zero encoding
            result_d    = '0;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (mag_q[SIZE_INT-1 -: COARSE_STEP] == '0) begin
          mag_d = mag_q << COARSE_STEP;
          exp_d = exp_q - EXP_COARSE;
        end else if (!mag_q[SIZE_INT-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_FINE;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        result_d    = pack_result(EXC_NORMAL_NUMBER, sign_q,
                                  w_rnd_exp[SIZE_EXPONENT-1:0],
                                  w_rnd_mantissa[SIZE_MANTISSA-2:0]);
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign resulted_number_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_to_fp_converter
//  Brief    : Self-checking bench for int_to_fp_converter: directed corner
//             cases plus randomized operands against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_to_fp_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic [31:0] int_number_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [33:0] resulted_number_o;

  int n_checks = 0;
  int n_fails  = 0;

  int_to_fp_converter dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .is_signed         (is_signed),
    .int_number_i      (int_number_i),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .resulted_number_o (resulted_number_o)
  );

  always #5 clk = ~clk;

  // Exact value of the operand, rounded half-to-even to 24 significant bits
  function automatic logic [33:0] model_result(input logic sg, input logic [31:0] v);
    logic            s;
    longint unsigned mag, m, rem, half;
    int              p, e, sh;
    s   = sg & v[31];
    mag = s ? (64'd1 << 32) - {32'd0, v} : {32'd0, v};
    if (mag == 0) return '0;
    p = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) p = i;
    e = 127 + p;
    if (p <= 23) begin
      m = mag << (23 - p);
    end else begin
      sh   = p - 23;
      m    = mag >> sh;
      rem  = mag - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == (64'd1 << 24)) begin
        m = m >> 1;
        e = e + 1;
      end
    end
    return {2'b01, s, e[7:0], m[22:0]};
  endfunction

  // Edges from accept to out_valid, from the leading-zero count
  function automatic int model_latency(input logic sg, input logic [31:0] v);
    logic            s;
    longint unsigned mag;
    int              p, lz;
    s   = sg & v[31];
    mag = s ? (64'd1 << 32) - {32'd0, v} : {32'd0, v};
    if (mag == 0) return 1;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    lz = 31 - p;
    return lz / 4 + lz % 4 + 1 + 2;
  endfunction

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: wait for idle, present operand, wait for result, consume
  task automatic convert(input logic sg, input logic [31:0] v, input int stall);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    in_valid     = 1'b1;
    is_signed    = sg;
    int_number_i = v;
    tick();
    guard = 0;
    while (!out_valid && guard < 40) begin
      in_valid     = 1'($urandom_range(0, 1));
      int_number_i = $urandom;
      is_signed    = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      n_checks++;
      n_fails++;
      $display("FAIL timeout: out_valid=0 required 1 for operand %h", v);
    end
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Scoreboard state used by the compare process
  logic        have_exp = 1'b0, seen = 1'b0;
  logic [33:0] exp_res = '0, pend_res = '0;
  int          exp_lat = 0, pend_lat = 0, edges = 0;
  logic        rst_s = 1'b1, acc_s = 1'b0, ret_s = 1'b0;

  initial begin
    fork
      // Compare process: applies the events of the edge just passed, checks outputs, samples the next edge
      forever begin
        @(negedge clk);
        if (rst_s) begin
          have_exp = 1'b0;
        end else if (acc_s) begin
          have_exp = 1'b1;
          seen     = 1'b0;
          edges    = 1;
          exp_res  = pend_res;
          exp_lat  = pend_lat;
        end else if (ret_s) begin
          have_exp = 1'b0;
        end else if (have_exp) begin
          edges++;
        end
        if (out_valid) begin
          if (!have_exp) begin
            chk("unexpected_out_valid", 34'(out_valid), 34'd0);
          end else begin
            if (!seen) begin
              chk("latency", 34'(edges), 34'(exp_lat));
              seen = 1'b1;
            end
            chk("result", resulted_number_o, exp_res);
            chk("busy_in_ready", 34'(in_ready), 34'd0);
          end
        end else if (have_exp && seen) begin
          chk("valid_dropped", 34'(out_valid), 34'd1);
          seen = 1'b0;
          have_exp = 1'b0;
        end else if (have_exp && edges >= exp_lat) begin
          chk("latency_late", 34'(edges + 1), 34'(exp_lat));
          have_exp = 1'b0;
        end else if (!have_exp && !rst_s) begin
          chk("idle_in_ready", 34'(in_ready), 34'd1);
        end
        rst_s = rst;
        acc_s = in_valid && in_ready && !rst;
        ret_s = out_valid && out_ready && !rst;
        if (acc_s) begin
          pend_res = model_result(is_signed, int_number_i);
          pend_lat = model_latency(is_signed, int_number_i);
        end
      end
    join_none

    // Model pinned against hand-computed values
    chk("model_1",          model_result(1'b1, 32'h00000001), {2'b01, 1'b0, 8'h7F, 23'h0});
    chk("model_m1_signed",  model_result(1'b1, 32'hFFFFFFFF), {2'b01, 1'b1, 8'h7F, 23'h0});
    chk("model_m1_unsigned",model_result(1'b0, 32'hFFFFFFFF), {2'b01, 1'b0, 8'h9F, 23'h0});
    chk("model_7fff",       model_result(1'b1, 32'h7FFFFFFF), {2'b01, 1'b0, 8'h9E, 23'h0});
    chk("model_8000",       model_result(1'b1, 32'h80000000), {2'b01, 1'b1, 8'h9E, 23'h0});
    chk("model_tie_even",   model_result(1'b0, 32'h01000001), {2'b01, 1'b0, 8'h97, 23'h0});
    chk("model_tie_up",     model_result(1'b0, 32'h01000003), {2'b01, 1'b0, 8'h97, 23'h2});
    chk("model_2",          model_result(1'b1, 32'h00000002), {2'b01, 1'b0, 8'h80, 23'h0});
    chk("model_zero",       model_result(1'b1, 32'h00000000), 34'h0);
    chk("model_lat_1",      34'(model_latency(1'b1, 32'h00000001)), 34'd13);
    chk("model_lat_8000",   34'(model_latency(1'b1, 32'h80000000)), 34'd3);
    chk("model_lat_zero",   34'(model_latency(1'b0, 32'h00000000)), 34'd1);

    repeat (2) tick();
    chk("reset_in_ready",  34'(in_ready), 34'd1);
    chk("reset_out_valid", 34'(out_valid), 34'd0);
    chk("reset_result",    resulted_number_o, 34'h0);
    rst = 1'b0;
    tick();

    // Directed corners
    convert(1'b1, 32'h00000001, 0);
    convert(1'b1, 32'hFFFFFFFF, 1);
    convert(1'b0, 32'hFFFFFFFF, 0);
    convert(1'b1, 32'h7FFFFFFF, 0);
    convert(1'b1, 32'h80000000, 2);
    convert(1'b0, 32'h01000001, 0);
    convert(1'b0, 32'h01000003, 0);
    convert(1'b1, 32'h00000000, 5);

    // Reset during normalisation discards the operation
    while (!in_ready) tick();
    in_valid     = 1'b1;
    is_signed    = 1'b1;
    int_number_i = 32'h00000001;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready",  34'(in_ready), 34'd1);
    chk("midrst_out_valid", 34'(out_valid), 34'd0);
    chk("midrst_result",    resulted_number_o, 34'h0);
    convert(1'b1, 32'h00000002, 0);

    // Randomized operands across magnitudes and signedness
    for (int k = 0; k < 250; k++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom >> $urandom_range(0, 31);
        2: v = -($urandom >> $urandom_range(0, 31));
        default: begin
          case ($urandom_range(0, 4))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h80000000;
            default: v = 32'h7FFFFFFF;
          endcase
        end
      endcase
      convert(1'($urandom_range(0, 1)), v, $urandom_range(0, 2));
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
